pmau_ctrl: RTL and testbench
============================

PMAU_CTRL -- requirements
Module: pmau_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  DATA_WIDTH  16  PMAU lane/result width
  ADDR_WIDTH  10  operand/result buffer address width
  CNT_WIDTH   8   row/output counter width
REQ-002 Ports, one per line: name  direction  width  meaning.
  CLK  in  1  single clock, rising edge
  RST  in  1  asynchronous, active-low reset
  start  in  1  one-cycle job request
  cfg_rows  in  CNT_WIDTH  8-lane rows per dot product
  cfg_outs  in  CNT_WIDTH  dot products per job
  cfg_a_base, cfg_x_base, cfg_y_base  in  ADDR_WIDTH each  buffer base addresses
  a_rd_en, x_rd_en  out  1  operand buffer read strobes
  a_rd_addr, x_rd_addr  out  ADDR_WIDTH  operand read addresses
  pm_a_valid, pm_x_valid  out  1  PMAU A_valid/X_valid
  pm_first_row, pm_last_row  out  1  PMAU First_Row/Last_Row
  pm_y_out  in  DATA_WIDTH  PMAU Y_out
  pm_y_valid  in  1  PMAU Y_valid
  y_wr_en  out  1  result write request
  y_wr_addr  out  ADDR_WIDTH  result address
  y_wr_data  out  DATA_WIDTH  result data
  y_wr_ready  in  1  result sink accepts write
  busy  out  1  job in progress
  done  out  1  one-cycle job-complete pulse
  err  out  1  sticky timeout flag (see Configuration)

Function
REQ-003 FSM states IDLE, ISSUE, DRAIN, WRITE, FIN; all outputs registered.
REQ-004 IDLE: start=1 latches all cfg_* and enters ISSUE with k=0, r=0; start outside IDLE is ignored.
REQ-005 start with cfg_rows=0 or cfg_outs=0: go directly to FIN, no reads, no writes.
REQ-006 ISSUE: one row per cycle; a_rd_en=x_rd_en=1, a_rd_addr=a_base+k*rows+r, x_rd_addr=x_base+r (modulo 2^ADDR_WIDTH).
REQ-007 Buffers have 1-cycle read latency; controller asserts pm_a_valid=pm_x_valid=1 exactly one cycle after each read, pm_first_row=(r==0), pm_last_row=(r==rows-1), so controls align with buffer data at PMAU.
REQ-008 Rows of one output are issued back-to-back with no gaps; after r=rows-1 issue, enter DRAIN.
REQ-009 DRAIN: wait for pm_y_valid=1; capture pm_y_out into y_wr_data, y_wr_addr=y_base+k, enter WRITE; pm_y_valid outside DRAIN ignored.
REQ-010 WRITE: y_wr_en=1 held with stable addr/data until cycle with y_wr_ready=1; then if k==outs-1 go FIN, else k++, r=0, go ISSUE.
REQ-011 FIN: done=1 for exactly one cycle, then IDLE.
REQ-012 busy=1 in every state except IDLE; busy=0 in the cycle done=1 is visible is not allowed -- busy drops the cycle after done.
REQ-013 k*rows product computed at full ADDR_WIDTH, truncated modulo 2^ADDR_WIDTH.

Reset
REQ-014 RST=0 asynchronously forces IDLE; all outputs, counters, latched cfg cleared to 0, including err.
REQ-015 Reset mid-job abandons the job: no done pulse, no further reads/writes after release.

Configuration
REQ-016 Macro PMAU_CTRL_TIMEOUT_EN defined: DRAIN counts cycles; 64 cycles without pm_y_valid sets err=1 (sticky until reset), skips remaining outputs, goes FIN.
REQ-017 Macro undefined: DRAIN waits indefinitely; err tied to 0.

Verification
REQ-018 rows=8, outs=1, bases 0: reads addr 0..7 on 8 consecutive cycles; first_row only on cycle 1, last_row only on cycle 8; Y=5 -> one write addr 0 data 5, done pulse.
REQ-019 rows=2, outs=3, a_base=16, x_base=4, y_base=100: A addrs 16,17,18,19,20,21; X addrs 4,5 repeated; writes to 100,101,102.
REQ-020 y_wr_ready held 0 for 5 cycles in WRITE: y_wr_en/addr/data stable, no new reads; accepted on 6th cycle.
REQ-021 cfg_outs=0: done pulse within 2 cycles of start, no a_rd_en/y_wr_en; start during busy ignored.
REQ-022 RST=0 mid-ISSUE: all outputs 0 immediately; after release, idle until new start.
REQ-023 PMAU_CTRL_TIMEOUT_EN defined, pm_y_valid never asserted: err=1 and done pulse 64 cycles after DRAIN entry; undefined: busy stays 1.

Source files
------------

// File: rtl/pmau_ctrl.sv
// PMAU job sequencer: issues operand buffer reads row by row, waits for each dot
// product, writes it to the result buffer. Optional DRAIN timeout: PMAU_CTRL_TIMEOUT_EN.
module pmau_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  cfg_rows,
  input  logic [CNT_WIDTH-1:0]  cfg_outs,
  input  logic [ADDR_WIDTH-1:0] cfg_a_base,
  input  logic [ADDR_WIDTH-1:0] cfg_x_base,
  input  logic [ADDR_WIDTH-1:0] cfg_y_base,
  output logic                  a_rd_en,
  output logic                  x_rd_en,
  output logic [ADDR_WIDTH-1:0] a_rd_addr,
  output logic [ADDR_WIDTH-1:0] x_rd_addr,
  output logic                  pm_a_valid,
  output logic                  pm_x_valid,
  output logic                  pm_first_row,
  output logic                  pm_last_row,
  input  logic [DATA_WIDTH-1:0] pm_y_out,
  input  logic                  pm_y_valid,
  output logic                  y_wr_en,
  output logic [ADDR_WIDTH-1:0] y_wr_addr,
  output logic [DATA_WIDTH-1:0] y_wr_data,
  input  logic                  y_wr_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, FIN} state_t;

  state_t                state, state_n;
  logic [CNT_WIDTH-1:0]  rows_q, rows_n;
  logic [CNT_WIDTH-1:0]  outs_q, outs_n;
  logic [ADDR_WIDTH-1:0] x_base_q, x_base_n;
  logic [ADDR_WIDTH-1:0] y_base_q, y_base_n;
  logic [CNT_WIDTH-1:0]  k, k_n;
  logic [CNT_WIDTH-1:0]  r, r_n;
  logic [ADDR_WIDTH-1:0] a_addr_n, x_addr_n, y_addr_n;
  logic [DATA_WIDTH-1:0] y_data_n;
  logic                  timeout;

  logic d_rd_en, d_pm_valid, d_first, d_last, d_wr_en, d_busy, d_done;

  // State, counters, latched configuration and all registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= IDLE;
      rows_q       <= '0;
      outs_q       <= '0;
      x_base_q     <= '0;
      y_base_q     <= '0;
      k            <= '0;
      r            <= '0;
      a_rd_en      <= 1'b0;
      x_rd_en      <= 1'b0;
      a_rd_addr    <= '0;
      x_rd_addr    <= '0;
      pm_a_valid   <= 1'b0;
      pm_x_valid   <= 1'b0;
      pm_first_row <= 1'b0;
      pm_last_row  <= 1'b0;
      y_wr_en      <= 1'b0;
      y_wr_addr    <= '0;
      y_wr_data    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      rows_q       <= rows_n;
      outs_q       <= outs_n;
      x_base_q     <= x_base_n;
      y_base_q     <= y_base_n;
      k            <= k_n;
      r            <= r_n;
      a_rd_en      <= d_rd_en;
      x_rd_en      <= d_rd_en;
      a_rd_addr    <= a_addr_n;
      x_rd_addr    <= x_addr_n;
      pm_a_valid   <= d_pm_valid;
      pm_x_valid   <= d_pm_valid;
      pm_first_row <= d_first;
      pm_last_row  <= d_last;
      y_wr_en      <= d_wr_en;
      y_wr_addr    <= y_addr_n;
      y_wr_data    <= y_data_n;
      busy         <= d_busy;
      done         <= d_done;
    end
  end

  // a_base + k*rows + r walks contiguously across outputs, so the A address is a
  // running pointer bumped once per issued row (same value modulo 2^ADDR_WIDTH).
  always_comb begin
    state_n  = state;
    rows_n   = rows_q;
    outs_n   = outs_q;
    x_base_n = x_base_q;
    y_base_n = y_base_q;
    k_n      = k;
    r_n      = r;
    a_addr_n = a_rd_addr;
    x_addr_n = x_rd_addr;
    y_addr_n = y_wr_addr;
    y_data_n = y_wr_data;
    case (state)
      IDLE: begin
        if (start) begin
          rows_n   = cfg_rows;
          outs_n   = cfg_outs;
          x_base_n = cfg_x_base;
          y_base_n = cfg_y_base;
          k_n      = '0;
          r_n      = '0;
          if (cfg_rows == '0 || cfg_outs == '0) begin
            state_n = FIN;
          end else begin
            state_n  = ISSUE;
            a_addr_n = cfg_a_base;
            x_addr_n = cfg_x_base;
          end
        end
      end
      ISSUE: begin
        if (r == rows_q - 1'b1) begin
          state_n = DRAIN;
        end else begin
          r_n      = r + 1'b1;
          a_addr_n = a_rd_addr + 1'b1;
          x_addr_n = x_rd_addr + 1'b1;
        end
      end
      DRAIN: begin
        if (pm_y_valid) begin
          state_n  = WRITE;
          y_data_n = pm_y_out;
          y_addr_n = y_base_q + ADDR_WIDTH'(k);
        end else if (timeout) begin
          state_n = FIN;
        end
      end
      WRITE: begin
        if (y_wr_ready) begin
          if (k == outs_q - 1'b1) begin
            state_n = FIN;
          end else begin
            state_n  = ISSUE;
            k_n      = k + 1'b1;
            r_n      = '0;
            a_addr_n = a_rd_addr + 1'b1;
            x_addr_n = x_base_q;
          end
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Controls for the next cycle; PMAU strobes trail the read by one cycle
  always_comb begin
    d_rd_en    = (state_n == ISSUE);
    d_wr_en    = (state_n == WRITE);
    d_busy     = (state_n != IDLE);
    d_done     = (state_n == FIN);
    d_pm_valid = (state == ISSUE);
    d_first    = (state == ISSUE) && (r == '0);
    d_last     = (state == ISSUE) && (r == rows_q - 1'b1);
  end

`ifdef PMAU_CTRL_TIMEOUT_EN
  logic [5:0] to_cnt;

  assign timeout = (state == DRAIN) && !pm_y_valid && (to_cnt == 6'd63);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (state != DRAIN)  to_cnt <= '0;
      else if (!pm_y_valid) to_cnt <= to_cnt + 1'b1;
      if (timeout) err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_pmau_ctrl.sv
// Scoreboard bench for pmau_ctrl: job model pushes expected reads, PMAU flags,
// writes and done pulses; negedge monitors pop and compare.
module tb_pmau_ctrl;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int CW = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          start;
  logic [CW-1:0] cfg_rows, cfg_outs;
  logic [AW-1:0] cfg_a_base, cfg_x_base, cfg_y_base;
  logic          a_rd_en, x_rd_en;
  logic [AW-1:0] a_rd_addr, x_rd_addr;
  logic          pm_a_valid, pm_x_valid, pm_first_row, pm_last_row;
  logic [DW-1:0] pm_y_out;
  logic          pm_y_valid;
  logic          y_wr_en;
  logic [AW-1:0] y_wr_addr;
  logic [DW-1:0] y_wr_data;
  logic          y_wr_ready;
  logic          busy, done, err;

  pmau_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RST(RST), .start(start),
    .cfg_rows(cfg_rows), .cfg_outs(cfg_outs),
    .cfg_a_base(cfg_a_base), .cfg_x_base(cfg_x_base), .cfg_y_base(cfg_y_base),
    .a_rd_en(a_rd_en), .x_rd_en(x_rd_en), .a_rd_addr(a_rd_addr), .x_rd_addr(x_rd_addr),
    .pm_a_valid(pm_a_valid), .pm_x_valid(pm_x_valid),
    .pm_first_row(pm_first_row), .pm_last_row(pm_last_row),
    .pm_y_out(pm_y_out), .pm_y_valid(pm_y_valid),
    .y_wr_en(y_wr_en), .y_wr_addr(y_wr_addr), .y_wr_data(y_wr_data), .y_wr_ready(y_wr_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  logic [55:0] all_outs;
  assign all_outs = {a_rd_en, x_rd_en, a_rd_addr, x_rd_addr, pm_a_valid, pm_x_valid,
                     pm_first_row, pm_last_row, y_wr_en, y_wr_addr, y_wr_data, busy, done, err};

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int jobs_done = 0;
  int done_cyc = 0;
  int drain_cyc = 0;
  int ready_delay = 0;
  bit pm_en = 1'b1;
  bit sticky_err = 1'b0;

  logic [AW-1:0]    rd_a_q[$];
  logic [AW-1:0]    rd_x_q[$];
  logic [1:0]       pm_q[$];
  logic [AW+DW-1:0] wr_q[$];
  logic [DW-1:0]    y_data_q[$];
  bit               done_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK) cyc++;

  // Read / PMAU-strobe / done monitor
  bit prev_rd = 1'b0;
  bit busy_drop = 1'b0;
  always @(negedge CLK) begin
    if (!RST) begin
      prev_rd   = 1'b0;
      busy_drop = 1'b0;
    end else begin
      if (a_rd_en) begin
        if (rd_a_q.size() == 0) chk("unexpected_read", a_rd_en, 0);
        else begin
          chk("a_rd_addr", a_rd_addr, rd_a_q.pop_front());
          chk("x_rd_addr", x_rd_addr, rd_x_q.pop_front());
          chk("x_rd_en", x_rd_en, 1);
        end
      end
      if (prev_rd || pm_a_valid || pm_x_valid)
        chk("pm_valid_latency", {pm_a_valid, pm_x_valid}, {prev_rd, prev_rd});
      prev_rd = a_rd_en;
      if (pm_a_valid) begin
        if (pm_q.size() == 0) chk("unexpected_pm_valid", pm_a_valid, 0);
        else chk("pm_first_last", {pm_first_row, pm_last_row}, pm_q.pop_front());
        if (pm_last_row) drain_cyc = cyc;
      end else if (pm_first_row || pm_last_row) begin
        chk("pm_flags_without_valid", {pm_first_row, pm_last_row}, 0);
      end
      if (a_rd_en && y_wr_en) chk("read_during_write", a_rd_en, 0);
      if (busy_drop) begin
        chk("busy_after_done", busy, 0);
        busy_drop = 1'b0;
      end
      if (done) begin
        if (done_q.size() == 0) chk("unexpected_done", done, 0);
        else begin
          chk("err_at_done", err, done_q.pop_front());
          chk("busy_with_done", busy, 1);
          chk("reads_left_at_done", rd_a_q.size(), 0);
          chk("writes_left_at_done", wr_q.size(), 0);
        end
        busy_drop = 1'b1;
        done_cyc  = cyc;
        jobs_done++;
      end
    end
  end

  // Result sink: ready after ready_delay stalled cycles; checks held writes and accepted data
  int wcnt = 0;
  bit hold_v = 1'b0;
  logic [AW+DW-1:0] hold_val;
  always @(negedge CLK) begin
    if (!RST || !y_wr_en) begin
      y_wr_ready = 1'b0;
      wcnt       = 0;
      hold_v     = 1'b0;
    end else begin
      if (hold_v) chk("write_stable", {y_wr_addr, y_wr_data}, hold_val);
      y_wr_ready = (wcnt >= ready_delay);
      wcnt++;
      if (y_wr_ready) begin
        if (wr_q.size() == 0) chk("unexpected_write", y_wr_en, 0);
        else chk("write_addr_data", {y_wr_addr, y_wr_data}, wr_q.pop_front());
        hold_v = 1'b0;
        wcnt   = 0;
      end else begin
        hold_v   = 1'b1;
        hold_val = {y_wr_addr, y_wr_data};
      end
    end
  end

  // PMAU model: answers each last row after a random delay; also emits decoy Y_valid
  // pulses in cycles where the controller is not draining.
  int ydly = -1;
  always @(negedge CLK) begin
    if (!RST) begin
      pm_y_valid = 1'b0;
      ydly       = -1;
    end else begin
      pm_y_valid = 1'b0;
      pm_y_out   = DW'($urandom);
      if (pm_en && pm_a_valid && pm_last_row && y_data_q.size() > 0) ydly = $urandom_range(0, 3);
      if (ydly == 0) begin
        pm_y_valid = 1'b1;
        pm_y_out   = y_data_q.pop_front();
        ydly       = -1;
      end else if (ydly > 0) begin
        ydly--;
      end else if ((a_rd_en || !busy) && $urandom_range(0, 3) == 0) begin
        pm_y_valid = 1'b1;
      end
    end
  end

  task automatic drive_start(input int rows, input int outs, input int ab, input int xb, input int yb);
    @(negedge CLK);
    cfg_rows   = CW'(rows);
    cfg_outs   = CW'(outs);
    cfg_a_base = AW'(ab);
    cfg_x_base = AW'(xb);
    cfg_y_base = AW'(yb);
    start      = 1'b1;
    @(negedge CLK);
    start      = 1'b0;
    cfg_rows   = CW'($urandom);
    cfg_outs   = CW'($urandom);
    cfg_a_base = AW'($urandom);
    cfg_x_base = AW'($urandom);
    cfg_y_base = AW'($urandom);
  endtask

  task automatic push_job(input int rows, input int outs, input int ab, input int xb, input int yb,
                          input int fixed_y, input bit to_exp);
    int kmax;
    logic [DW-1:0] y;
    kmax = to_exp ? 1 : outs;
    for (int k = 0; k < kmax; k++) begin
      for (int r = 0; r < rows; r++) begin
        rd_a_q.push_back(AW'(ab + k * rows + r));
        rd_x_q.push_back(AW'(xb + r));
        pm_q.push_back({r == 0, r == rows - 1});
      end
      if (!to_exp) begin
        y = (fixed_y >= 0) ? DW'(fixed_y) : DW'($urandom);
        y_data_q.push_back(y);
        wr_q.push_back({AW'(yb + k), y});
      end
    end
  endtask

  task automatic run_job(input int rows, input int outs, input int ab, input int xb, input int yb,
                         input int fixed_y, input int rdly, input bit poke, input bit to_exp);
    int base, bound;
    ready_delay = rdly;
    push_job(rows, outs, ab, xb, yb, fixed_y, to_exp);
    done_q.push_back(to_exp | sticky_err);
    base = jobs_done;
    drive_start(rows, outs, ab, xb, yb);
    if (poke) begin
      repeat (2) @(negedge CLK);
      cfg_rows = 1; cfg_outs = 1; cfg_a_base = 7; start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
    end
    bound = rows * outs + outs * (rdly + 10) + 200;
    for (int c = 0; c < bound && jobs_done == base; c++) @(negedge CLK);
    chk("job_done", jobs_done - base, 1);
    repeat (2) @(negedge CLK);
  endtask

  task automatic flush_all();
    rd_a_q.delete(); rd_x_q.delete(); pm_q.delete();
    wr_q.delete(); y_data_q.delete(); done_q.delete();
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    #2 RST = 1'b0;
    #1 chk("outputs_in_reset", all_outs, 0);
    flush_all();
    sticky_err = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    #2 RST = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int base, st;
    RST = 1'b0; start = 1'b0;
    cfg_rows = '0; cfg_outs = '0; cfg_a_base = '0; cfg_x_base = '0; cfg_y_base = '0;
    pm_y_out = '0; pm_y_valid = 1'b0; y_wr_ready = 1'b0;
    #12 chk("reset_outputs", all_outs, 0);
    #10 RST = 1'b1;
    repeat (2) @(negedge CLK);

    run_job(8, 1, 0, 0, 0, 5, 0, 0, 0);
    run_job(2, 3, 16, 4, 100, -1, 1, 1, 0);
    run_job(2, 2, 30, 40, 50, -1, 5, 0, 0);
    run_job(255, 5, 1000, 900, 1022, -1, 2, 0, 0);

    for (int i = 0; i < 8; i++)
      run_job($urandom_range(1, 6), $urandom_range(1, 4), $urandom_range(0, 1023),
              $urandom_range(0, 1023), $urandom_range(0, 1023), -1, $urandom_range(0, 3), i[0], 0);

    // Degenerate jobs; start is held into the FIN cycle and must be ignored there
    for (int i = 0; i < 2; i++) begin
      done_q.push_back(sticky_err);
      base = jobs_done;
      @(negedge CLK);
      cfg_rows = (i == 0) ? CW'(4) : CW'(0);
      cfg_outs = (i == 0) ? CW'(0) : CW'(3);
      start = 1'b1;
      st = cyc;
      @(negedge CLK);
      @(negedge CLK);
      start = 1'b0;
      for (int c = 0; c < 10 && jobs_done == base; c++) @(negedge CLK);
      chk("zero_job_done", jobs_done - base, 1);
      chk("zero_job_latency", (done_cyc - st) <= 2, 1);
      repeat (5) @(negedge CLK);
    end

    // Reset in the middle of ISSUE abandons the job
    push_job(40, 1, 0, 0, 0, -1, 1'b1);
    drive_start(40, 1, 0, 0, 0);
    repeat (4) @(negedge CLK);
    pulse_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      chk("idle_after_reset", {busy, a_rd_en, y_wr_en, done}, 0);
    end

`ifdef PMAU_CTRL_TIMEOUT_EN
    pm_en = 1'b0;
    run_job(3, 2, 8, 9, 10, -1, 0, 0, 1);
    chk("timeout_latency", done_cyc - drain_cyc, 64);
    sticky_err = 1'b1;
    pm_en = 1'b1;
    run_job(2, 1, 20, 21, 22, -1, 1, 0, 0);
    chk("err_sticky", err, 1);
`else
    pm_en = 1'b0;
    push_job(3, 1, 8, 9, 10, -1, 1'b1);
    drive_start(3, 1, 8, 9, 10);
    repeat (150) @(negedge CLK);
    chk("busy_while_waiting", busy, 1);
    chk("err_tied_low", err, 0);
    pulse_reset();
    pm_en = 1'b1;
    repeat (3) @(negedge CLK);
`endif

    repeat (3) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
